// File: rtl/gpio_bank.sv
// gpio_bank: register-mapped GPIO bank with input synchroniser and bus read/write port.
// Edge-interrupt logic (IRQ_EN/IRQ_STAT, irq) is built only when GPIO_BANK_IRQ_EN is defined.
module gpio_bank #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [2:0]       bus_addr,
   input  logic [WIDTH-1:0] bus_wdata,
   input  logic             bus_we,
   input  logic             bus_re,
   output logic [WIDTH-1:0] bus_rdata,
   output logic             bus_rvalid,
   input  logic [WIDTH-1:0] pin_in,
   output logic [WIDTH-1:0] pin_out,
   output logic [WIDTH-1:0] pin_oe,
   output logic             irq
);
   localparam logic [2:0] A_OUT = 3'd0, A_DIR = 3'd1, A_IN = 3'd2, A_SET = 3'd3,
                          A_CLR = 3'd4, A_TGL = 3'd5, A_IEN = 3'd6, A_IST = 3'd7;
   logic [WIDTH-1:0] out_q, dir_q, out_d, rd_val, in_val;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   assign in_val  = sync_q[SYNC_STAGES-1];
   assign pin_out = out_q;
   assign pin_oe  = dir_q;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= pin_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end
   always_comb begin
      out_d = out_q;
      if (bus_we) begin
         case (bus_addr)
            A_OUT:   out_d = bus_wdata;
            A_SET:   out_d = out_q | bus_wdata;
            A_CLR:   out_d = out_q & ~bus_wdata;
            A_TGL:   out_d = out_q ^ bus_wdata;
            default: out_d = out_q;
         endcase
      end
   end
`ifdef GPIO_BANK_IRQ_EN
   logic [WIDTH-1:0] en_q, stat_q, prev_q, rise, w1c;
   logic [SYNC_STAGES:0] arm_q;
   // Edge detection stays disarmed until the chain holds real pad samples after reset.
   assign rise = in_val & ~prev_q & {WIDTH{arm_q[SYNC_STAGES]}};
   assign w1c  = (bus_we && bus_addr == A_IST) ? bus_wdata : '0;
   assign irq  = |(stat_q & en_q);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         en_q   <= '0;
         stat_q <= '0;
         prev_q <= '0;
         arm_q  <= '0;
      end else begin
         prev_q <= in_val;
         arm_q  <= {arm_q[SYNC_STAGES-1:0], 1'b1};
         if (bus_we && bus_addr == A_IEN) en_q <= bus_wdata;
         stat_q <= (stat_q & ~w1c) | rise;
      end
   end
`else
   assign irq = 1'b0;
`endif
   always_comb begin
      rd_val = '0;
      case (bus_addr)
         A_OUT:   rd_val = out_q;
         A_DIR:   rd_val = dir_q;
         A_IN:    rd_val = in_val;
`ifdef GPIO_BANK_IRQ_EN
         A_IEN:   rd_val = en_q;
         A_IST:   rd_val = stat_q;
`endif
         default: rd_val = '0;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_q      <= '0;
         dir_q      <= '0;
         bus_rdata  <= '0;
         bus_rvalid <= 1'b0;
      end else begin
         out_q      <= out_d;
         bus_rvalid <= bus_re;
         if (bus_we && bus_addr == A_DIR) dir_q <= bus_wdata;
         if (bus_re) bus_rdata <= rd_val;
      end
   end
endmodule
